// File: rtl/game_timer_pkg.sv
// Shared state encoding and default constants for the game_timer slice.
package game_timer_pkg;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    PAUSED  = 2'd2,
    EXPIRED = 2'd3
  } state_e;

  localparam int DEF_CNT_W       = 7;
  localparam int DEF_STEP        = 30;
  localparam int DEF_WARN_THRESH = 5;

endpackage

// File: rtl/game_timer_tick_prescaler.sv
// Divides the clock into count ticks: one tick every TICK_DIV enabled clocks.
module tick_prescaler #(
  parameter int TICK_DIV = 1
) (
  input  logic clk,
  input  logic restart,
  input  logic clr,
  input  logic en,
  output logic tick
);

  localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] cnt_q, cnt_d;

  assign tick = en && (cnt_q == LAST);

  // Holding en low without clr freezes the phase so a resume continues from it.
  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (en) begin
      cnt_d = tick ? '0 : cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge restart) begin
    if (!restart) cnt_q <= '0;
    else          cnt_q <= cnt_d;
  end

endmodule

// File: rtl/game_timer.sv
// Countdown game timer with difficulty-scaled load, pause, bonus time and expiry pulse.
// Optional low-time warning output is built when GAME_TIMER_WARN_EN is defined.
module game_timer
  import game_timer_pkg::*;
#(
  parameter int CNT_W       = DEF_CNT_W,
  parameter int STEP        = DEF_STEP,
  parameter int LEVEL_W     = 2,
  parameter int TICK_DIV    = 1,
  parameter int WARN_THRESH = DEF_WARN_THRESH
) (
  input  logic               clk,
  input  logic               restart,
  input  logic               start,
  input  logic               abort,
  input  logic               pause,
  input  logic [LEVEL_W-1:0] level,
  input  logic               bonus_vld,
  input  logic [CNT_W-1:0]   bonus_amt,
  output logic [CNT_W-1:0]   counter,
  output logic [1:0]         state,
  output logic               expired,
  output logic               warn
);

  localparam int PROD_W = CNT_W + LEVEL_W;
  localparam logic [CNT_W-1:0] MAX_CNT = '1;

  function automatic logic [CNT_W-1:0] calc_max(input logic [LEVEL_W-1:0] lvl);
    logic [PROD_W-1:0] prod;
    prod = PROD_W'(lvl) * PROD_W'(STEP);
    if (prod > PROD_W'(MAX_CNT)) return MAX_CNT;
    return prod[CNT_W-1:0];
  endfunction

  state_e           state_q, state_d;
  logic [CNT_W-1:0] counter_q, counter_d;
  logic             expired_q, expired_d;
  logic             ps_clr, ps_en, tick;
  logic [CNT_W-1:0] max_live;
  logic [CNT_W-1:0] dec_cnt;
  logic [CNT_W:0]   sum_cnt;
  logic [CNT_W-1:0] next_cnt;

  assign max_live = calc_max(level);

  // The prescaler only advances while actively counting; pause freezes it.
  assign ps_en  = (state_q == RUN || state_q == PAUSED) && !pause && !abort && !start;
  assign ps_clr = !(state_q == RUN || state_q == PAUSED) || abort || start;

  tick_prescaler #(.TICK_DIV(TICK_DIV)) u_prescaler (
    .clk     (clk),
    .restart (restart),
    .clr     (ps_clr),
    .en      (ps_en),
    .tick    (tick)
  );

  assign dec_cnt  = counter_q - {{(CNT_W-1){1'b0}}, tick};
  assign sum_cnt  = {1'b0, dec_cnt} + {1'b0, (bonus_vld ? bonus_amt : {CNT_W{1'b0}})};
  assign next_cnt = sum_cnt[CNT_W] ? MAX_CNT : sum_cnt[CNT_W-1:0];

  always_comb begin
    state_d   = state_q;
    counter_d = counter_q;
    expired_d = 1'b0;
    if (abort) begin
      state_d   = IDLE;
      counter_d = max_live;
    end else if (start) begin
      counter_d = max_live;
      if (max_live == '0) begin
        state_d   = EXPIRED;
        expired_d = 1'b1;
      end else begin
        state_d = RUN;
      end
    end else begin
      unique case (state_q)
        IDLE:    counter_d = max_live;
        RUN, PAUSED: begin
          state_d   = pause ? PAUSED : RUN;
          counter_d = next_cnt;
          // Expiry only on a tick; bonus alone never drives the count to zero.
          if (tick && next_cnt == '0) begin
            state_d   = EXPIRED;
            expired_d = 1'b1;
          end
        end
        EXPIRED: counter_d = '0;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk or negedge restart) begin
    if (!restart) begin
      state_q   <= IDLE;
      counter_q <= '0;
      expired_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      counter_q <= counter_d;
      expired_q <= expired_d;
    end
  end

`ifdef GAME_TIMER_WARN_EN
  logic warn_q, warn_d;

  // Computed from next-state values so warn lines up with the registered count.
  always_comb begin
    warn_d = (state_d == RUN || state_d == PAUSED) && (counter_d != '0) &&
             (32'(counter_d) <= 32'(WARN_THRESH));
  end

  always_ff @(posedge clk or negedge restart) begin
    if (!restart) warn_q <= 1'b0;
    else          warn_q <= warn_d;
  end

  assign warn = warn_q;
`else
  assign warn = 1'b0;
`endif

  assign counter = counter_q;
  assign state   = state_q;
  assign expired = expired_q;

endmodule

// File: tb/tb_game_timer.sv
// Directed self-checking bench for game_timer (TICK_DIV=1 and TICK_DIV=4 instances).
module tb_game_timer;
  import game_timer_pkg::*;

`ifdef GAME_TIMER_WARN_EN
  localparam bit WARN_ON = 1'b1;
`else
  localparam bit WARN_ON = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       restart, start, abort, pause, bonus_vld;
  logic [1:0] level;
  logic [6:0] bonus_amt;
  logic [6:0] counter, counter4;
  logic [1:0] state, state4;
  logic       expired, expired4, warn, warn4;

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  game_timer dut (
    .clk(clk), .restart(restart), .start(start), .abort(abort), .pause(pause),
    .level(level), .bonus_vld(bonus_vld), .bonus_amt(bonus_amt),
    .counter(counter), .state(state), .expired(expired), .warn(warn)
  );

  game_timer #(.TICK_DIV(4)) dut4 (
    .clk(clk), .restart(restart), .start(start), .abort(abort), .pause(pause),
    .level(level), .bonus_vld(bonus_vld), .bonus_amt(bonus_amt),
    .counter(counter4), .state(state4), .expired(expired4), .warn(warn4)
  );

  task automatic step(input int n = 1);
    for (int i = 0; i < n; i++) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_start(input logic [1:0] lvl);
    level = lvl;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    restart = 1'b0; start = 1'b0; abort = 1'b0; pause = 1'b0;
    bonus_vld = 1'b0; bonus_amt = '0; level = 2'd1;
    #2;
    vectors++;
    if (counter !== 7'd0 || state !== 2'(IDLE) || expired !== 1'b0 || warn !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL reset_hold: counter=%0d state=%0d expired=%b warn=%b, want 0/0/0/0",
               counter, state, expired, warn);
    end
    step();
    restart = 1'b1;
    step();
    vectors++;
    if (counter !== 7'd30 || state !== 2'(IDLE)) begin
      miscompares++;
      $display("[TB] FAIL reset_preview: counter=%0d state=%0d, want 30/IDLE", counter, state);
    end
  endtask

  task automatic test_countdown();
    pulse_start(2'd1);
    vectors++;
    if (counter !== 7'd30 || state !== 2'(RUN)) begin
      miscompares++;
      $display("[TB] FAIL load_l1: counter=%0d state=%0d, want 30/RUN", counter, state);
    end
    for (int k = 29; k >= 1; k--) begin
      step();
      vectors++;
      if (counter !== 7'(k) || expired !== 1'b0 || warn !== (WARN_ON && k <= 5)) begin
        miscompares++;
        $display("[TB] FAIL countdown: counter=%0d expired=%b warn=%b, want %0d/0/%b",
                 counter, expired, warn, k, (WARN_ON && k <= 5));
      end
    end
    step();
    vectors++;
    if (counter !== 7'd0 || state !== 2'(EXPIRED) || expired !== 1'b1 || warn !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL expire: counter=%0d state=%0d expired=%b warn=%b, want 0/EXPIRED/1/0",
               counter, state, expired, warn);
    end
    bonus_vld = 1'b1; bonus_amt = 7'd9;
    step();
    bonus_vld = 1'b0;
    vectors++;
    if (counter !== 7'd0 || state !== 2'(EXPIRED) || expired !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL expired_hold: counter=%0d state=%0d expired=%b, want 0/EXPIRED/0",
               counter, state, expired);
    end
  endtask

  task automatic test_levels();
    pulse_start(2'd2);
    vectors++;
    if (counter !== 7'd60 || state !== 2'(RUN)) begin
      miscompares++;
      $display("[TB] FAIL load_l2: counter=%0d state=%0d, want 60/RUN", counter, state);
    end
    level = 2'd3;
    step();
    vectors++;
    if (counter !== 7'd59) begin
      miscompares++;
      $display("[TB] FAIL level_change_ignored: counter=%0d, want 59", counter);
    end
    pulse_start(2'd3);
    vectors++;
    if (counter !== 7'd90 || state !== 2'(RUN)) begin
      miscompares++;
      $display("[TB] FAIL load_l3: counter=%0d state=%0d, want 90/RUN", counter, state);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    vectors++;
    if (counter !== 7'd90 || state !== 2'(IDLE)) begin
      miscompares++;
      $display("[TB] FAIL abort: counter=%0d state=%0d, want 90/IDLE", counter, state);
    end
    level = 2'd1;
    step();
    vectors++;
    if (counter !== 7'd30 || state !== 2'(IDLE)) begin
      miscompares++;
      $display("[TB] FAIL idle_preview: counter=%0d state=%0d, want 30/IDLE", counter, state);
    end
    pulse_start(2'd0);
    vectors++;
    if (counter !== 7'd0 || state !== 2'(EXPIRED) || expired !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL load_l0: counter=%0d state=%0d expired=%b, want 0/EXPIRED/1",
               counter, state, expired);
    end
  endtask

  task automatic test_pause();
    pulse_start(2'd1);
    step(10);
    vectors++;
    if (counter !== 7'd20) begin
      miscompares++;
      $display("[TB] FAIL pre_pause: counter=%0d, want 20", counter);
    end
    pause = 1'b1;
    for (int i = 0; i < 5; i++) begin
      step();
      vectors++;
      if (counter !== 7'd20 || state !== 2'(PAUSED)) begin
        miscompares++;
        $display("[TB] FAIL paused_hold: counter=%0d state=%0d, want 20/PAUSED", counter, state);
      end
    end
    pause = 1'b0;
    step();
    vectors++;
    if (counter !== 7'd19 || state !== 2'(RUN)) begin
      miscompares++;
      $display("[TB] FAIL resume: counter=%0d state=%0d, want 19/RUN", counter, state);
    end
  endtask

  task automatic test_bonus();
    pulse_start(2'd3);
    bonus_vld = 1'b1; bonus_amt = 7'd11;
    step();
    vectors++;
    if (counter !== 7'd100) begin
      miscompares++;
      $display("[TB] FAIL bonus_tick: counter=%0d, want 100", counter);
    end
    bonus_amt = 7'd50;
    step();
    bonus_vld = 1'b0;
    vectors++;
    if (counter !== 7'd127) begin
      miscompares++;
      $display("[TB] FAIL bonus_saturate: counter=%0d, want 127", counter);
    end
    step();
    vectors++;
    if (counter !== 7'd126) begin
      miscompares++;
      $display("[TB] FAIL after_saturate: counter=%0d, want 126", counter);
    end
    pulse_start(2'd1);
    step(29);
    bonus_vld = 1'b1; bonus_amt = 7'd3;
    step();
    bonus_vld = 1'b0;
    vectors++;
    if (counter !== 7'd3 || state !== 2'(RUN) || expired !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL bonus_at_one: counter=%0d state=%0d expired=%b, want 3/RUN/0",
               counter, state, expired);
    end
    pause = 1'b1;
    step();
    bonus_vld = 1'b1; bonus_amt = 7'd5;
    step();
    bonus_vld = 1'b0; pause = 1'b0;
    vectors++;
    if (counter !== 7'd8 || state !== 2'(PAUSED)) begin
      miscompares++;
      $display("[TB] FAIL bonus_paused: counter=%0d state=%0d, want 8/PAUSED", counter, state);
    end
    abort = 1'b1;
    step();
    abort = 1'b0;
    bonus_vld = 1'b1; bonus_amt = 7'd50;
    step();
    bonus_vld = 1'b0;
    vectors++;
    if (counter !== 7'd30 || state !== 2'(IDLE)) begin
      miscompares++;
      $display("[TB] FAIL bonus_idle: counter=%0d state=%0d, want 30/IDLE", counter, state);
    end
  endtask

  task automatic test_restart_async();
    pulse_start(2'd2);
    step(15);
    vectors++;
    if (counter !== 7'd45 || state !== 2'(RUN)) begin
      miscompares++;
      $display("[TB] FAIL pre_restart: counter=%0d state=%0d, want 45/RUN", counter, state);
    end
    #2 restart = 1'b0;
    #1;
    vectors++;
    if (counter !== 7'd0 || state !== 2'(IDLE) || expired !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL async_restart: counter=%0d state=%0d expired=%b, want 0/IDLE/0",
               counter, state, expired);
    end
    step();
    restart = 1'b1;
    step();
    vectors++;
    if (counter !== 7'd60 || state !== 2'(IDLE)) begin
      miscompares++;
      $display("[TB] FAIL restart_release: counter=%0d state=%0d, want 60/IDLE", counter, state);
    end
  endtask

  task automatic test_tick_div();
    pulse_start(2'd1);
    step(3);
    vectors++;
    if (counter4 !== 7'd30 || state4 !== 2'(RUN)) begin
      miscompares++;
      $display("[TB] FAIL div4_hold: counter=%0d state=%0d, want 30/RUN", counter4, state4);
    end
    step();
    vectors++;
    if (counter4 !== 7'd29) begin
      miscompares++;
      $display("[TB] FAIL div4_first_tick: counter=%0d, want 29", counter4);
    end
    step(92);
    vectors++;
    if (counter4 !== 7'd6 || warn4 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL div4_six: counter=%0d warn=%b, want 6/0", counter4, warn4);
    end
    step(4);
    vectors++;
    if (counter4 !== 7'd5 || warn4 !== WARN_ON) begin
      miscompares++;
      $display("[TB] FAIL div4_warn_rise: counter=%0d warn=%b, want 5/%b", counter4, warn4, WARN_ON);
    end
    step(19);
    vectors++;
    if (counter4 !== 7'd1 || expired4 !== 1'b0 || warn4 !== WARN_ON) begin
      miscompares++;
      $display("[TB] FAIL div4_one: counter=%0d expired=%b warn=%b, want 1/0/%b",
               counter4, expired4, warn4, WARN_ON);
    end
    step();
    vectors++;
    if (counter4 !== 7'd0 || state4 !== 2'(EXPIRED) || expired4 !== 1'b1 || warn4 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL div4_expire: counter=%0d state=%0d expired=%b warn=%b, want 0/EXPIRED/1/0",
               counter4, state4, expired4, warn4);
    end
    step();
    vectors++;
    if (expired4 !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL div4_pulse_width: expired=%b, want 0", expired4);
    end
  endtask

  initial begin
    test_reset();
    test_countdown();
    test_levels();
    test_pause();
    test_bonus();
    test_restart_async();
    test_tick_div();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
